// File: rtl/bh_run_ctrl_if.sv
// bh_run_ctrl_if: host-side handshake bundle for bh_run_ctrl.
//   Command channel : i_host_cmd[1:0] / i_host_cmd_valid / o_host_cmd_ready
//   Program load    : i_host_data[2:0] / i_host_last / i_host_data_valid / o_host_data_ready
//   Tape dump       : o_host_rdata[7:0] / o_host_rvalid / i_host_rready
//   Single step     : i_step (sampled with an accepted run command)
// master = host side, slave = controller side.
interface bh_run_ctrl_if;
    logic [1:0] i_host_cmd;
    logic       i_host_cmd_valid;
    logic       o_host_cmd_ready;
    logic [2:0] i_host_data;
    logic       i_host_last;
    logic       i_host_data_valid;
    logic       o_host_data_ready;
    logic [7:0] o_host_rdata;
    logic       o_host_rvalid;
    logic       i_host_rready;
    logic       i_step;

    modport master (
        output i_host_cmd, i_host_cmd_valid, i_host_data, i_host_last,
               i_host_data_valid, i_host_rready, i_step,
        input  o_host_cmd_ready, o_host_data_ready, o_host_rdata, o_host_rvalid
    );

    modport slave (
        input  i_host_cmd, i_host_cmd_valid, i_host_data, i_host_last,
               i_host_data_valid, i_host_rready, i_step,
        output o_host_cmd_ready, o_host_data_ready, o_host_rdata, o_host_rvalid
    );
endinterface

// File: rtl/bh_run_ctrl.sv
// bh_run_ctrl: host-facing run controller for a small tape-machine core.
// Loads a 256-word program, runs the core until opcode 000, and dumps the
// 256-cell tape back to the host.
// Ports:
//   i_clock, i_reset_n          clock, synchronous active-low reset
//   host (bh_run_ctrl_if.slave) command / program-load / tape-dump handshakes, i_step
//   o_prgmem_we/waddr/wdata     program memory write port
//   i_core_instr                opcode at the core PC
//   o_core_en, o_core_rst_n     core advance enable, core state reset
//   i_core_tape_*               core tape access request
//   o_tape_addr/we/wdata        tape memory port, i_tape_rdata combinational read
//   o_state, o_cycles           FSM state, executed-instruction count
// Configuration: define BH_RUN_CTRL_STEP_EN to let a run issued with i_step=1
// execute a single instruction and then halt.
module bh_run_ctrl #(
    parameter int unsigned CYCLE_W = 16
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    bh_run_ctrl_if.slave       host,
    output logic               o_prgmem_we,
    output logic [7:0]         o_prgmem_waddr,
    output logic [2:0]         o_prgmem_wdata,
    input  logic [2:0]         i_core_instr,
    output logic               o_core_en,
    output logic               o_core_rst_n,
    input  logic [7:0]         i_core_tape_addr,
    input  logic               i_core_tape_in,
    input  logic [7:0]         i_core_tape_data,
    output logic [7:0]         o_tape_addr,
    output logic               o_tape_we,
    output logic [7:0]         o_tape_wdata,
    input  logic [7:0]         i_tape_rdata,
    output logic [2:0]         o_state,
    output logic [CYCLE_W-1:0] o_cycles
);
    localparam int unsigned    ADDR_W   = 8;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

`ifdef BH_RUN_CTRL_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_HALT = 3'd3,
        ST_DUMP = 3'd4
    } state_e;

    localparam logic [1:0] CMD_LOAD = 2'b01;
    localparam logic [1:0] CMD_RUN  = 2'b10;
    localparam logic [1:0] CMD_DUMP = 2'b11;

    state_e             state_q,   state_d;
    logic [ADDR_W-1:0]  waddr_q,   waddr_d;
    logic [ADDR_W-1:0]  daddr_q,   daddr_d;
    logic [CYCLE_W-1:0] cycles_q,  cycles_d;
    logic               started_q, started_d;
    logic               step_q,    step_d;

    logic cmd_ready, cmd_fire, data_ready, data_fire, rvalid, rd_fire, core_en;

    // Handshake decode; everything is forced quiet while reset is held.
    always_comb begin
        cmd_ready  = i_reset_n && ((state_q == ST_IDLE) || (state_q == ST_HALT));
        cmd_fire   = cmd_ready && host.i_host_cmd_valid;
        data_ready = i_reset_n && (state_q == ST_LOAD);
        data_fire  = data_ready && host.i_host_data_valid;
        rvalid     = i_reset_n && (state_q == ST_DUMP);
        rd_fire    = rvalid && host.i_host_rready;
        // Opcode 000 is halt and never counts as an executed instruction.
        core_en    = i_reset_n && (state_q == ST_RUN) && (i_core_instr != 3'b000);
    end

    // Next-state and counter logic.
    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        daddr_d   = daddr_q;
        cycles_d  = cycles_q;
        started_d = started_q;
        step_d    = step_q;

        if (core_en && (cycles_q != '1)) begin
            cycles_d = cycles_q + CYCLE_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (cmd_fire) begin
                    case (host.i_host_cmd)
                        CMD_LOAD: begin
                            state_d   = ST_LOAD;
                            waddr_d   = '0;
                            cycles_d  = '0;
                            started_d = 1'b0;
                        end
                        CMD_RUN: begin
                            state_d   = ST_RUN;
                            started_d = 1'b1;
                            step_d    = STEP_EN && host.i_step;
                        end
                        CMD_DUMP: begin
                            state_d = ST_DUMP;
                            daddr_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                // Stop at the last word or the top of memory; never wrap.
                if (data_fire) begin
                    if (host.i_host_last || (waddr_q == ADDR_MAX)) begin
                        state_d = ST_IDLE;
                    end else begin
                        waddr_d = waddr_q + ADDR_W'(1);
                    end
                end
            end
            ST_RUN: begin
                // A step run halts after its one executed instruction.
                if ((i_core_instr == 3'b000) || step_q) begin
                    state_d = ST_HALT;
                end
            end
            ST_DUMP: begin
                if (rd_fire) begin
                    if (daddr_q == ADDR_MAX) begin
                        state_d = started_q ? ST_HALT : ST_IDLE;
                    end else begin
                        daddr_d = daddr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            waddr_q   <= '0;
            daddr_q   <= '0;
            cycles_q  <= '0;
            started_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            daddr_q   <= daddr_d;
            cycles_q  <= cycles_d;
            started_q <= started_d;
            step_q    <= step_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        host.o_host_cmd_ready  = cmd_ready;
        host.o_host_data_ready = data_ready;
        host.o_host_rvalid     = rvalid;
        host.o_host_rdata      = i_tape_rdata;
        o_prgmem_we            = data_fire;
        o_prgmem_waddr         = waddr_q;
        o_prgmem_wdata         = host.i_host_data;
        o_core_en              = core_en;
        o_core_rst_n           = i_reset_n && (state_q != ST_IDLE) && (state_q != ST_LOAD);
        o_tape_addr            = (state_q == ST_RUN) ? i_core_tape_addr : daddr_q;
        o_tape_we              = core_en && i_core_tape_in;
        o_tape_wdata           = i_core_tape_data;
        o_state                = 3'(state_q);
        o_cycles               = cycles_q;
    end
endmodule

// File: tb/tb_bh_run_ctrl.sv
// tb_bh_run_ctrl: scoreboard bench for bh_run_ctrl with a tiny core model.
// Core opcodes modelled: 001 '+' (tape[ptr]++), 010 '>' (ptr++), 000 halt,
// others no-op.
module tb_bh_run_ctrl;
    localparam int unsigned CYCLE_W = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               tb_init;
    bh_run_ctrl_if      hif ();
    logic               prgmem_we;
    logic [7:0]         prgmem_waddr;
    logic [2:0]         prgmem_wdata;
    logic [2:0]         core_instr;
    logic               core_en;
    logic               core_rst_n;
    logic [7:0]         core_tape_addr;
    logic               core_tape_in;
    logic [7:0]         core_tape_data;
    logic [7:0]         tape_addr;
    logic               tape_we;
    logic [7:0]         tape_wdata;
    logic [7:0]         tape_rdata;
    logic [2:0]         state;
    logic [CYCLE_W-1:0] cycles;

    bh_run_ctrl #(.CYCLE_W(CYCLE_W)) dut (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .host             (hif.slave),
        .o_prgmem_we      (prgmem_we),
        .o_prgmem_waddr   (prgmem_waddr),
        .o_prgmem_wdata   (prgmem_wdata),
        .i_core_instr     (core_instr),
        .o_core_en        (core_en),
        .o_core_rst_n     (core_rst_n),
        .i_core_tape_addr (core_tape_addr),
        .i_core_tape_in   (core_tape_in),
        .i_core_tape_data (core_tape_data),
        .o_tape_addr      (tape_addr),
        .o_tape_we        (tape_we),
        .o_tape_wdata     (tape_wdata),
        .i_tape_rdata     (tape_rdata),
        .o_state          (state),
        .o_cycles         (cycles)
    );

    always #5 clk = ~clk;

    // Memories and core model.
    logic [2:0] prog [256];
    logic [7:0] tape [256];
    logic [7:0] pc, ptr;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) begin
                prog[i] <= 3'd0;
                tape[i] <= 8'(i * 3 + 1);
            end
        end else begin
            if (prgmem_we) prog[prgmem_waddr] <= prgmem_wdata;
            if (tape_we)   tape[tape_addr]    <= tape_wdata;
        end
    end

    always @(posedge clk) begin
        if (!core_rst_n) begin
            pc  <= 8'd0;
            ptr <= 8'd0;
        end else if (core_en) begin
            pc <= pc + 8'd1;
            if (core_instr == 3'd2) ptr <= ptr + 8'd1;
        end
    end

    assign core_instr     = prog[pc];
    assign core_tape_addr = ptr;
    assign core_tape_in   = (core_instr == 3'd1);
    assign core_tape_data = tape[ptr] + 8'd1;
    assign tape_rdata     = tape[tape_addr];

    // Scoreboard.
    int total = 0;
    int bad   = 0;
    logic [10:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    logic [15:0] exp_tw [$];
    int wr_cnt = 0, rd_cnt = 0, en_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_rdata = 8'd0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT presents an output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prgmem_we) begin
                wr_cnt++;
                if (exp_wr.size() == 0) chk("prg_wr_unexpected", 32'({prgmem_waddr, prgmem_wdata}), 32'h7ff);
                else chk("prg_wr", 32'({prgmem_waddr, prgmem_wdata}), 32'(exp_wr.pop_front()));
            end
            if (tape_we) begin
                if (exp_tw.size() == 0) chk("tape_wr_unexpected", 32'({tape_addr, tape_wdata}), 32'hffff_ffff);
                else chk("tape_wr", 32'({tape_addr, tape_wdata}), 32'(exp_tw.pop_front()));
            end
            if (core_en) en_cnt++;
            if (prev_stall && hif.o_host_rvalid) chk("rdata_stable", 32'(hif.o_host_rdata), 32'(prev_rdata));
            if (hif.o_host_rvalid && hif.i_host_rready) begin
                rd_cnt++;
                if (exp_rd.size() == 0) chk("dump_unexpected", 32'(hif.o_host_rdata), 32'h1ff);
                else chk("dump", 32'(hif.o_host_rdata), 32'(exp_rd.pop_front()));
            end
        end
        prev_stall = rst_n && hif.o_host_rvalid && !hif.i_host_rready;
        prev_rdata = hif.o_host_rdata;
    end

    task automatic send_cmd(input logic [1:0] c, input logic stp);
        logic ok;
        @(posedge clk); #1;
        hif.i_host_cmd       = c;
        hif.i_host_cmd_valid = 1'b1;
        hif.i_step           = stp;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = hif.o_host_cmd_ready;
            @(posedge clk); #1;
        end
        hif.i_host_cmd_valid = 1'b0;
        hif.i_step           = 1'b0;
        chk("cmd_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_word(input logic [2:0] d, input logic lst);
        logic ok;
        hif.i_host_data       = d;
        hif.i_host_last       = lst;
        hif.i_host_data_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = hif.o_host_data_ready;
            @(posedge clk); #1;
        end
        hif.i_host_data_valid = 1'b0;
        hif.i_host_last       = 1'b0;
        chk("word_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_state(input string name, input logic [2:0] s, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (state == s) break;
        end
        chk(name, 32'(state), 32'(s));
    endtask

    function automatic logic [7:0] dump_val(input int i);
        return (i == 0) ? 8'd4 : 8'(i * 3 + 1);
    endfunction

    initial begin
        rst_n = 1'b0;
        tb_init = 1'b1;
        hif.i_host_cmd = 2'b00;
        hif.i_host_cmd_valid = 1'b0;
        hif.i_host_data = 3'd0;
        hif.i_host_last = 1'b0;
        hif.i_host_data_valid = 1'b0;
        hif.i_host_rready = 1'b0;
        hif.i_step = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cycles", 32'(cycles), 32'd0);
        chk("rst_core_en", 32'(core_en), 32'd0);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("rst_rvalid", 32'(hif.o_host_rvalid), 32'd0);
        chk("rst_prg_we", 32'(prgmem_we), 32'd0);
        chk("rst_tape_we", 32'(tape_we), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tb_init = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(hif.o_host_cmd_ready), 32'd1);
        chk("post_rst_data_ready", 32'(hif.o_host_data_ready), 32'd0);

        // Load 2,4,6,0 with last on the fourth word.
        exp_wr.push_back({8'd0, 3'd2});
        exp_wr.push_back({8'd1, 3'd4});
        exp_wr.push_back({8'd2, 3'd6});
        exp_wr.push_back({8'd3, 3'd0});
        send_cmd(2'b01, 1'b0);
        send_word(3'd2, 1'b0);
        send_word(3'd4, 1'b0);
        send_word(3'd6, 1'b0);
        send_word(3'd0, 1'b1);
        @(negedge clk);
        chk("load4_state", 32'(state), 32'd0);
        chk("load4_writes", 32'(wr_cnt), 32'd4);

        // Program "+ + + halt": three increments of tape[0] (initial value 1).
        exp_wr.push_back({8'd0, 3'd1});
        exp_wr.push_back({8'd1, 3'd1});
        exp_wr.push_back({8'd2, 3'd1});
        exp_wr.push_back({8'd3, 3'd0});
        send_cmd(2'b01, 1'b0);
        send_word(3'd1, 1'b0);
        send_word(3'd1, 1'b0);
        send_word(3'd1, 1'b0);
        send_word(3'd0, 1'b1);
        exp_tw.push_back({8'd0, 8'd2});
        exp_tw.push_back({8'd0, 8'd3});
        exp_tw.push_back({8'd0, 8'd4});
        en_cnt = 0;
        send_cmd(2'b10, 1'b0);
        wait_state("run_halt", 3'd3, 50);
        chk("run_cycles", 32'(cycles), 32'd3);
        chk("run_en_cnt", 32'(en_cnt), 32'd3);
        chk("halt_core_rst_n", 32'(core_rst_n), 32'd1);

        // Dump with rready toggling every cycle.
        for (int i = 0; i < 256; i++) exp_rd.push_back(dump_val(i));
        rd_cnt = 0;
        send_cmd(2'b11, 1'b0);
        for (int n = 0; n < 1200 && state != 3'd3; n++) begin
            hif.i_host_rready = ~hif.i_host_rready;
            @(posedge clk); #1;
        end
        hif.i_host_rready = 1'b0;
        @(negedge clk);
        chk("dump_transfers", 32'(rd_cnt), 32'd256);
        chk("dump_end_state", 32'(state), 32'd3);
        chk("dump_cycles_kept", 32'(cycles), 32'd3);

        // Load 300 words without last: only 256 are written.
        wr_cnt = 0;
        for (int i = 0; i < 256; i++) exp_wr.push_back({8'(i), 3'(i)});
        send_cmd(2'b01, 1'b0);
        hif.i_host_data_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            hif.i_host_data = 3'(i);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("load300_writes", 32'(wr_cnt), 32'd256);
        chk("load300_state", 32'(state), 32'd0);
        chk("load300_not_ready", 32'(hif.o_host_data_ready), 32'd0);
        chk("load300_cycles", 32'(cycles), 32'd0);
        @(posedge clk); #1;
        hif.i_host_data_valid = 1'b0;

        // Reset in the middle of a dump, with address 17 on the bus.
        for (int i = 0; i < 17; i++) exp_rd.push_back(dump_val(i));
        rd_cnt = 0;
        send_cmd(2'b11, 1'b0);
        hif.i_host_rready = 1'b1;
        for (int n = 0; n < 100 && rd_cnt != 17; n++) begin
            @(posedge clk); #1;
        end
        hif.i_host_rready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid", 32'(hif.o_host_rvalid), 32'd0);
        @(negedge clk);
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("midrst_count", 32'(rd_cnt), 32'd17);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_cmd_ready", 32'(hif.o_host_cmd_ready), 32'd1);

        // Program "> > halt" run with i_step set.
        exp_wr.push_back({8'd0, 3'd2});
        exp_wr.push_back({8'd1, 3'd2});
        exp_wr.push_back({8'd2, 3'd0});
        send_cmd(2'b01, 1'b0);
        send_word(3'd2, 1'b0);
        send_word(3'd2, 1'b0);
        send_word(3'd0, 1'b1);
`ifdef BH_RUN_CTRL_STEP_EN
        send_cmd(2'b10, 1'b1);
        wait_state("step1_halt", 3'd3, 20);
        chk("step1_cycles", 32'(cycles), 32'd1);
        send_cmd(2'b10, 1'b1);
        wait_state("step2_halt", 3'd3, 20);
        chk("step2_cycles", 32'(cycles), 32'd2);
        send_cmd(2'b10, 1'b1);
        wait_state("step3_halt", 3'd3, 20);
        chk("step3_cycles", 32'(cycles), 32'd2);
`else
        send_cmd(2'b10, 1'b1);
        wait_state("freerun_halt", 3'd3, 20);
        chk("freerun_cycles", 32'(cycles), 32'd2);
`endif

        // Nothing left unconsumed in the scoreboard.
        @(negedge clk);
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        chk("tw_queue_empty", 32'(exp_tw.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bh_run_ctrl.md
BH_RUN_CTRL -- requirements
Module: bh_run_ctrl

Interface
REQ-001 SHALL have parameter: CYCLE_W, 16, width of executed-instruction counter.
REQ-002 SHALL have port: i_clock  in  1  sole clock, rising edge.
REQ-003 SHALL have port: i_reset_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have ports: i_host_cmd  in  2  00 none, 01 load, 10 run, 11 dump; i_host_cmd_valid  in  1; o_host_cmd_ready  out  1.
REQ-005 SHALL have ports: i_host_data  in  3  instruction to load; i_host_last  in  1  final word; i_host_data_valid  in  1; o_host_data_ready  out  1.
REQ-006 SHALL have ports: o_host_rdata  out  8  tape cell; o_host_rvalid  out  1; i_host_rready  in  1; i_step  in  1  single-step request.
REQ-007 SHALL have ports: o_prgmem_we  out  1; o_prgmem_waddr  out  8; o_prgmem_wdata  out  3.
REQ-008 SHALL have ports: i_core_instr  in  3  program memory read data at core PC; o_core_en  out  1  core advance enable; o_core_rst_n  out  1  core PC/SP/PTR/skip-flag reset.
REQ-009 SHALL have ports: i_core_tape_addr  in  8; i_core_tape_in  in  1; i_core_tape_data  in  8; o_tape_addr  out  8; o_tape_we  out  1; o_tape_wdata  out  8; i_tape_rdata  in  8  combinational read.
REQ-010 SHALL have ports: o_state  out  3  current state; o_cycles  out  CYCLE_W  executed instructions.

Function
REQ-011 SHALL implement states IDLE=0, LOAD=1, RUN=2, HALT=3, DUMP=4.
REQ-012 SHALL assert o_host_cmd_ready only in IDLE and HALT; cmd accepted when valid&&ready; cmds in other states are not accepted.
REQ-013 SHALL on load: next state LOAD, write address counter cleared to 0, o_cycles cleared.
REQ-014 SHALL in LOAD assert o_host_data_ready; each valid&&ready cycle drives o_prgmem_we=1, waddr=counter, wdata=i_host_data, counter+1.
REQ-015 SHALL leave LOAD to IDLE after the word with i_host_last=1 or after writing address 255, whichever first; no wrap to 0.
REQ-016 SHALL hold o_core_rst_n=0 in IDLE and LOAD, 1 otherwise.
REQ-017 SHALL on run: next state RUN; o_cycles retained (run from HALT resumes).
REQ-018 SHALL drive o_core_en combinationally = (state==RUN) && i_core_instr!=3'b000; opcode 000 is halt and is never executed.
REQ-019 SHALL in RUN go to HALT on the cycle i_core_instr==000 is sampled.
REQ-020 SHALL increment o_cycles on every cycle o_core_en=1; saturates at all-ones.
REQ-021 SHALL in RUN route core to tape: o_tape_addr=i_core_tape_addr, o_tape_we=i_core_tape_in&&o_core_en, o_tape_wdata=i_core_tape_data; otherwise o_tape_we=0.
REQ-022 SHALL on dump: next state DUMP, dump address cleared to 0; o_tape_addr=dump address.
REQ-023 SHALL in DUMP drive o_host_rvalid=1, o_host_rdata=i_tape_rdata; address advances only on rvalid&&rready; data stable while stalled.
REQ-024 SHALL leave DUMP on transfer of address 255 to HALT if core was started since last load, else IDLE.
REQ-025 SHALL drive o_prgmem_we, o_host_rvalid, o_host_data_ready low outside LOAD/DUMP respectively.

Reset
REQ-026 SHALL on i_reset_n=0 at a rising edge, from any state including mid-LOAD/DUMP: state IDLE, counters 0, o_cycles 0.
REQ-027 SHALL hold during and after reset: o_core_en=0, o_core_rst_n=0, o_tape_we=0, o_prgmem_we=0, o_host_rvalid=0, o_host_cmd_ready=1 once reset deasserted.

Configuration
REQ-028 SHALL support macro BH_RUN_CTRL_STEP_EN: when defined, run accepted with i_step=1 enables exactly one core instruction then HALT (or HALT immediately if opcode 000); when undefined, i_step is ignored and run always free-runs.

Verification
REQ-029 SHALL test load: words 2,4,6,0 with last on 4th -> prgmem writes addr 0..3, state IDLE.
REQ-030 SHALL test run: program "+ + + halt" -> o_core_en high 3 cycles, o_cycles=3, HALT, tape write on core address.
REQ-031 SHALL test dump with rready toggled every other cycle -> 256 transfers, rdata stable during stall, HALT at end.
REQ-032 SHALL test load of 300 words with no last -> 256 writes, addr 255 final, words 257+ not accepted.
REQ-033 SHALL test reset asserted mid-DUMP at address 17 -> IDLE next cycle, rvalid=0, core_rst_n=0.
REQ-034 SHALL test with BH_RUN_CTRL_STEP_EN: run+i_step on program "> > halt" -> two steps give o_cycles=1 then 2, third gives 2 and HALT.
